// File: rtl/ps2_key_ctrl_pkg.sv
// Shared definitions for the PS/2 key controller: prefix/error byte values
// and the fetch state encoding used by the FIFO drain sequencer.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } fetch_state_t;

    // Bytes that are never key codes and are dropped with an error pulse.
    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// FIFO-side handshake bundle between ps2_keyboard (master) and the key
// controller (slave): head byte, non-empty flag, overflow and pop strobe.
interface ps2_key_ctrl_if;
    import ps2_pkg::*;

    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       nextdata_n;

    modport master (
        output ready,
        output data,
        output overflow,
        input  nextdata_n
    );

    modport slave (
        input  ready,
        input  data,
        input  overflow,
        output nextdata_n
    );

endinterface

// File: rtl/ps2_key_ctrl_hold_tracker.sv
// Held-key tracking and key-press counter for ps2_key_ctrl.
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN -- when defined, a make
// event repeating the currently held key is flagged for suppression.
module ps2_hold_tracker
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    // candidate event being decoded this cycle (combinational)
    input  logic [7:0]       cand_code,
    input  logic             cand_ext,
    input  logic             cand_brk,
    output logic             suppress,
    // registered event as presented on the controller outputs
    input  logic             ev_valid,
    input  logic [7:0]       ev_code,
    input  logic             ev_ext,
    input  logic             ev_brk,
    output logic             held,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] key_count
);

    logic held_ext;
    logic brk_match;

    assign brk_match = held && (ev_code == held_code) && (ev_ext == held_ext);

`ifdef PS2_TYPEMATIC_FILTER_EN
    // A make that repeats the held key is an auto-repeat and is swallowed.
    assign suppress = held && !cand_brk &&
                      (cand_code == held_code) && (cand_ext == held_ext);
`else
    logic unused_cand;
    assign unused_cand = ^{cand_code, cand_ext, cand_brk};
    assign suppress    = 1'b0;
`endif

    // Update held key on makes, release on matching breaks, count makes.
    always_ff @(posedge clk) begin
        if (rst) begin
            held      <= 1'b0;
            held_code <= 8'h00;
            held_ext  <= 1'b0;
            key_count <= '0;
        end else if (ev_valid) begin
            if (!ev_brk) begin
                held      <= 1'b1;
                held_code <= ev_code;
                held_ext  <= ev_ext;
                key_count <= key_count + 1'b1;
            end else if (brk_match) begin
                held      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 key controller: drains scan-code bytes from the ps2_keyboard FIFO,
// folds E0/F0 prefixes into single key events, tracks the held key, counts
// presses and latches FIFO overflow.
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN (typematic repeat filter,
// implemented in ps2_hold_tracker).
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    ps2_key_ctrl_if.slave    fifo,
    output logic             ev_valid,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_brk,
    output logic             held,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] key_count,
    output logic             ovf_sticky,
    output logic             err
);

    fetch_state_t state;
    logic [7:0]   byte_q;
    logic         pre_ext;
    logic         pre_brk;
    logic         nextdata_n;

    logic         byte_is_ext;
    logic         byte_is_brk;
    logic         byte_is_err;
    logic         suppress;

    assign fifo.nextdata_n = nextdata_n;

    // Classify the captured byte; only meaningful while in POP.
    always_comb begin
        byte_is_ext = 1'b0;
        byte_is_brk = 1'b0;
        byte_is_err = 1'b0;
        byte_is_ext = (byte_q == PS2_EXT);
        byte_is_brk = (byte_q == PS2_BRK);
        byte_is_err = is_err_byte(byte_q);
    end

    // Fetch sequencer: capture head byte, pop it for one cycle, then give
    // the FIFO a cycle to refresh ready before looking again.
    always_ff @(posedge clk) begin
        if (clrn) begin
            state      <= IDLE;
            nextdata_n <= 1'b1;
            byte_q     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    nextdata_n <= 1'b1;
                    if (fifo.ready) begin
                        byte_q     <= fifo.data;
                        nextdata_n <= 1'b0;
                        state      <= POP;
                    end
                end
                POP: begin
                    nextdata_n <= 1'b1;
                    state      <= GAP;
                end
                GAP: begin
                    nextdata_n <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    nextdata_n <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Prefix folding and event/err generation, done once per popped byte.
    always_ff @(posedge clk) begin
        if (clrn) begin
            pre_ext  <= 1'b0;
            pre_brk  <= 1'b0;
            ev_valid <= 1'b0;
            ev_code  <= 8'h00;
            ev_ext   <= 1'b0;
            ev_brk   <= 1'b0;
            err      <= 1'b0;
        end else begin
            ev_valid <= 1'b0;
            err      <= 1'b0;
            if (state == POP) begin
                if (byte_is_ext) begin
                    pre_ext <= 1'b1;
                end else if (byte_is_brk) begin
                    pre_brk <= 1'b1;
                end else if (byte_is_err) begin
                    pre_ext <= 1'b0;
                    pre_brk <= 1'b0;
                    err     <= 1'b1;
                end else begin
                    pre_ext <= 1'b0;
                    pre_brk <= 1'b0;
                    if (!suppress) begin
                        ev_valid <= 1'b1;
                        ev_code  <= byte_q;
                        ev_ext   <= pre_ext;
                        ev_brk   <= pre_brk;
                    end
                end
            end
        end
    end

    // Overflow is latched and only reset clears it.
    always_ff @(posedge clk) begin
        if (clrn) begin
            ovf_sticky <= 1'b0;
        end else if (fifo.overflow) begin
            ovf_sticky <= 1'b1;
        end
    end

    ps2_hold_tracker #(
        .CNT_W (CNT_W)
    ) u_hold (
        .clk       (clk),
        .rst       (clrn),
        .cand_code (byte_q),
        .cand_ext  (pre_ext),
        .cand_brk  (pre_brk),
        .suppress  (suppress),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_brk    (ev_brk),
        .held      (held),
        .held_code (held_code),
        .key_count (key_count)
    );

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: byte-level reference model of the
// prefix/hold/count rules, FIFO model driving the handshake, and a per-cycle
// compare process.
module tb_ps2_key_ctrl;
    import ps2_pkg::*;

`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       clk;
    logic       clrn;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic       held;
    logic [7:0] held_code;
    logic [7:0] key_count;
    logic       ovf_sticky;
    logic       err;

    ps2_key_ctrl_if fifo_if ();

    ps2_key_ctrl #(.CNT_W(8)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .fifo       (fifo_if.slave),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_brk     (ev_brk),
        .held       (held),
        .held_code  (held_code),
        .key_count  (key_count),
        .ovf_sticky (ovf_sticky),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       held;
        logic [7:0] hcode;
        logic [7:0] cnt;
    } item_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    item_t      exp_q[$];
    item_t      post_item;
    bit         post_pending = 0;
    bit         chk_en = 0;
    bit         exp_ovf = 0;
    int         n_ev = 0;
    int         n_err = 0;
    int         nd_lows = 0;

    // reference model state
    bit         m_ext, m_brk, m_held, m_hext;
    logic [7:0] m_hcode;
    logic [7:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0;
        m_hcode = 8'h00; m_cnt = 8'h00;
    endtask

    // Apply the byte rules to one FIFO byte, queueing what the DUT must show.
    task automatic push_byte(input logic [7:0] b);
        item_t it;
        bit    sup;
        fifo_q.push_back(b);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'h00 || b == 8'hFF) begin
            m_ext = 0; m_brk = 0;
            it = '0;
            it.is_err = 1;
            exp_q.push_back(it);
        end else begin
            sup = FILT && m_held && !m_brk && (b == m_hcode) && (m_ext == m_hext);
            if (!sup) begin
                if (!m_brk) begin
                    m_held = 1; m_hcode = b; m_hext = m_ext; m_cnt = m_cnt + 8'd1;
                end else if (m_held && b == m_hcode && m_ext == m_hext) begin
                    m_held = 0;
                end
                it.is_err = 0;
                it.code   = b;
                it.ext    = m_ext;
                it.brk    = m_brk;
                it.held   = m_held;
                it.hcode  = m_hcode;
                it.cnt    = m_cnt;
                exp_q.push_back(it);
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // FIFO model: pops on an edge where nextdata_n was low, then refreshes.
    initial begin
        bit nd_s;
        fifo_if.ready = 1'b0;
        fifo_if.data  = 8'h00;
        forever begin
            @(negedge clk);
            nd_s = fifo_if.nextdata_n;
            @(posedge clk);
            if (!nd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
            #1;
            fifo_if.ready = (fifo_q.size() > 0);
            fifo_if.data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        end
    end

    // Per-cycle compare against the model queue.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (!chk_en) begin
                post_pending = 0;
            end else begin
                if (post_pending) begin
                    chk("held", {31'd0, held}, {31'd0, post_item.held});
                    chk("held_code", {24'd0, held_code}, {24'd0, post_item.hcode});
                    chk("key_count", {24'd0, key_count}, {24'd0, post_item.cnt});
                    post_pending = 0;
                end
                chk("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, exp_ovf});
                if (!fifo_if.nextdata_n) nd_lows++;
                if (ev_valid || err) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pulse: got ev_valid=%0b err=%0b expected none at %0t",
                                 ev_valid, err, $time);
                    end else begin
                        it = exp_q.pop_front();
                        chk("err", {31'd0, err}, {31'd0, it.is_err});
                        chk("ev_valid", {31'd0, ev_valid}, {31'd0, !it.is_err});
                        if (!it.is_err) begin
                            chk("ev_code", {24'd0, ev_code}, {24'd0, it.code});
                            chk("ev_ext", {31'd0, ev_ext}, {31'd0, it.ext});
                            chk("ev_brk", {31'd0, ev_brk}, {31'd0, it.brk});
                            post_item = it;
                            post_pending = 1;
                        end
                    end
                    if (ev_valid) n_ev++;
                    if (err) n_err++;
                end
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_nextdata_n"}, {31'd0, fifo_if.nextdata_n}, 32'd1);
        chk({tag, "_ev_valid"}, {31'd0, ev_valid}, 32'd0);
        chk({tag, "_ev_code"}, {24'd0, ev_code}, 32'd0);
        chk({tag, "_ev_ext"}, {31'd0, ev_ext}, 32'd0);
        chk({tag, "_ev_brk"}, {31'd0, ev_brk}, 32'd0);
        chk({tag, "_held"}, {31'd0, held}, 32'd0);
        chk({tag, "_held_code"}, {24'd0, held_code}, 32'd0);
        chk({tag, "_key_count"}, {24'd0, key_count}, 32'd0);
        chk({tag, "_ovf_sticky"}, {31'd0, ovf_sticky}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic clear_bench();
        model_reset();
        exp_q.delete();
        exp_ovf = 0;
        n_ev = 0; n_err = 0; nd_lows = 0;
    endtask

    task automatic do_reset();
        chk_en = 0;
        fifo_q.delete();
        @(posedge clk);
        #1;
        fifo_if.overflow = 1'b0;
        clrn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b0;
        clear_bench();
        check_zero_outputs("reset");
        chk_en = 1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || post_pending) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_timeout"}, {31'd0, (n < 5000)}, 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic random_bytes(input int count);
        logic [7:0] b;
        int r;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 15);
            if (r < 2) b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else if (r == 4) b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            else if (r < 8) b = 8'h1C;
            else if (r < 10) b = 8'h75;
            else b = 8'($urandom_range(1, 8'hDF));
            push_byte(b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end
    endtask

    initial begin
        int n;
        clrn = 1'b1;
        fifo_if.overflow = 1'b0;
        clear_bench();
        do_reset();

        // 1C F0 1C: press and release
        push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
        drain("seq1");
        chk("seq1_events", n_ev, 32'd2);
        chk("seq1_count", {24'd0, key_count}, 32'd1);
        chk("seq1_held", {31'd0, held}, 32'd0);
        chk("seq1_pops", nd_lows, 32'd3);

        // Extended key make/break
        do_reset();
        push_byte(8'hE0); push_byte(8'h75); push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
        drain("seq2");
        chk("seq2_events", n_ev, 32'd2);
        chk("seq2_count", {24'd0, key_count}, 32'd1);
        chk("seq2_pops", nd_lows, 32'd5);

        // Typematic repeats
        do_reset();
        push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
        drain("seq3");
        chk("seq3_events", n_ev, FILT ? 32'd2 : 32'd4);
        chk("seq3_count", {24'd0, key_count}, FILT ? 32'd1 : 32'd3);
        chk("seq3_held", {31'd0, held}, 32'd0);

        // Error byte drops a pending break prefix
        do_reset();
        push_byte(8'hF0); push_byte(8'h00); push_byte(8'h1C);
        drain("seq4");
        chk("seq4_errs", n_err, 32'd1);
        chk("seq4_events", n_ev, 32'd1);
        chk("seq4_held_code", {24'd0, held_code}, 32'h1C);
        chk("seq4_count", {24'd0, key_count}, 32'd1);

        // Counter wrap: 300 makes alternating two codes
        do_reset();
        for (int i = 0; i < 300; i++) push_byte((i % 2 == 0) ? 8'h1C : 8'h1D);
        drain("wrap");
        chk("wrap_count", {24'd0, key_count}, 32'd44);
        chk("wrap_events", n_ev, 32'd300);

        // Overflow pulse then heavy random traffic
        do_reset();
        chk("ovf_before", {31'd0, ovf_sticky}, 32'd0);
        @(posedge clk);
        #1 fifo_if.overflow = 1'b1;
        @(posedge clk);
        exp_ovf = 1;
        #1 fifo_if.overflow = 1'b0;
        random_bytes(700);
        drain("rand_ovf");
        chk("rand_ovf_many_events", {31'd0, (n_ev >= 255)}, 32'd1);
        chk("rand_ovf_sticky", {31'd0, ovf_sticky}, 32'd1);

        // Reset during POP discards the byte and the partial prefix
        do_reset();
        push_byte(8'h1C);
        drain("mid_pre");
        chk("mid_pre_held", {31'd0, held}, 32'd1);
        push_byte(8'hE0);
        n = 0;
        while (fifo_if.nextdata_n && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_pop_seen", {31'd0, (n < 100)}, 32'd1);
        chk_en = 0;
        clrn = 1'b1;
        @(posedge clk);
        #1;
        check_zero_outputs("mid_reset");
        clrn = 1'b0;
        clear_bench();
        chk_en = 1;
        push_byte(8'h1C);
        drain("mid_post");
        chk("mid_post_events", n_ev, 32'd1);
        chk("mid_post_count", {24'd0, key_count}, 32'd1);

        // More random traffic without overflow
        do_reset();
        random_bytes(300);
        drain("rand2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Sequencer between the `ps2_keyboard` receive FIFO and the display/ASCII path. It drains scan-code bytes with the `ready`/`nextdata_n` handshake and folds `E0` (extended) and `F0` (break) prefixes into single key events. It tracks the currently held key, counts key presses, and latches sticky FIFO overflow. The display logic consumes its event outputs instead of raw FIFO bytes.

## Interface
- `CNT_W`, default 8: width of the key-press counter.
- `clk  in  1`: system clock.
- `clrn  in  1`: reset. One clock; reset is synchronous and active-high.
- `ready  in  1`: FIFO non-empty, from `ps2_keyboard`.
- `data  in  8`: FIFO head byte, valid while `ready`=1.
- `overflow  in  1`: FIFO overflow flag from `ps2_keyboard`.
- `nextdata_n  out  1`: active-low pop strobe to the FIFO. Registered.
- `ev_valid  out  1`: one-cycle pulse; a key event is available.
- `ev_code  out  8`: event scan code, without prefixes. Held until the next event.
- `ev_ext  out  1`: event carried an `E0` prefix.
- `ev_brk  out  1`: event is a release (`F0` prefix).
- `held  out  1`: a key is currently held.
- `held_code  out  8`: code of the held key. `held_ext` is internal.
- `key_count  out  CNT_W`: number of counted key presses. Wraps modulo 2^CNT_W.
- `ovf_sticky  out  1`: set once `overflow` is seen. Cleared only by reset.
- `err  out  1`: one-cycle pulse when the controller drops a `00` or `FF` byte.

## Operation
- Fetch FSM states:
  - IDLE: if `ready`=1, capture `data` into `byte_q` and go to POP.
  - POP: `nextdata_n`=0 for exactly this cycle; go to GAP.
  - GAP: `nextdata_n`=1, lets the FIFO update `ready`; go to IDLE.
  - `ready` is ignored in POP and GAP.
  - Peak rate is one byte per 3 cycles.
- Decode of `byte_q` happens in POP:
  - `E0`: set `pre_ext`. No event.
  - `F0`: set `pre_brk`. No event.
  - `00` or `FF`: clear both prefixes, pulse `err`. No event.
  - Any other byte: emit an event with `ev_code`=byte, `ev_ext`=`pre_ext`, `ev_brk`=`pre_brk`, then clear both prefixes.
  - A repeated prefix, e.g. `E0 E0`, stays set; it is not an error.
- Hold tracking:
  - A make event sets `held`=1 and `held_code`/`held_ext` to the event values.
  - A break event whose code and ext match the held key clears `held`.
  - A break event that does not match leaves `held` unchanged. The event is still emitted.
- Counting: `key_count` increments on every emitted make event. It never increments on break events.
- Overflow: `ovf_sticky` sets on the cycle after `overflow`=1. Draining continues normally.

## Timing
- Reset values: `nextdata_n`=1, all other outputs 0, FSM in IDLE, `pre_ext`=`pre_brk`=0, `held_ext`=0.
- Event latency:
  - `ready` is sampled 1 at edge n (IDLE).
  - `nextdata_n`=0 during cycle n+1.
  - `ev_valid`, `ev_*`, `err` update at edge n+1, together with `nextdata_n`.
  - `held*`, `key_count` update at edge n+2.
- Reset mid-operation: `clrn` during POP forces `nextdata_n`=1 at the next edge. The popped byte and any partial prefix are discarded.
- If `overflow` and an event occur in the same cycle, both take effect.
- A `key_count` wrap from 2^CNT_W−1 to 0 raises no flag.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN` defined:
  - A make event whose code and ext equal the held key while `held`=1 is suppressed: no `ev_valid`, no count.
  - The next byte after the suppressed code is processed normally.
- Not defined: every make code, including typematic repeats, is emitted and counted.

## Structure
- Package `ps2_pkg` holds:
  - constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `PS2_ERR0`=8'h00, `PS2_ERR1`=8'hFF;
  - the fetch-state enum (IDLE, POP, GAP).
- One sub-module, `ps2_hold_tracker`: `held`/`held_code`/`held_ext`, the typematic filter, and `key_count`. It is fed by the decoded event.

## Test plan
- FIFO sequence `1C F0 1C`:
  - `ev_valid` pulses twice: code 1C with brk=0, then code 1C with brk=1.
  - `key_count`=1; `held` goes 1, then 0.
  - `nextdata_n` low exactly 3 times.
- FIFO sequence `E0 75 E0 F0 75`: events are (75, ext=1, brk=0) and (75, ext=1, brk=1). No event for the prefix bytes.
- FIFO sequence `1C 1C 1C F0 1C`:
  - With the filter: 2 events, `key_count`=1.
  - Without the filter: 4 events, `key_count`=3.
- Byte `00` while `pre_brk`=1: `err` pulses, no event, and the next `1C` is emitted as a make.
- `overflow` pulse for 1 cycle: `ovf_sticky`=1 from the next cycle, held through 255 subsequent events and cleared only by `clrn`.
- `clrn` asserted during POP:
  - `nextdata_n`=1 next cycle, all outputs zero.
  - A following `1C` produces a make event with ext=0, brk=0.
